popcount_seq: RTL and testbench

POPCOUNT_SEQ -- requirements
Module: popcount_seq

---
 rtl/popcount_pkg.sv | 19 +
 rtl/popcount_seq_count_ones.sv | 17 +
 rtl/popcount_seq.sv | 106 ++++++++++
 tb/tb_popcount_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared definitions for the sequential popcount block: FSM states,
// default geometry and a sizing helper.
package popcount_pkg;

  localparam int DEFAULT_WIDTH = 128;
  localparam int DEFAULT_CHUNK = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Chunk index needs at least one bit even when the whole vector is one chunk.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/popcount_seq_count_ones.sv
// Purely combinational population count of a WIDTH-bit slice.
module count_ones #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CW-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle popcount: a captured vector is counted CHUNK bits per cycle and
// the total is presented with a valid/ready handshake.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int CHUNK    = DEFAULT_CHUNK,
  localparam int NCHUNK   = WIDTH / CHUNK,
  localparam int CNTWIDTH = $clog2(WIDTH + 1),
  localparam int CCW      = $clog2(CHUNK + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_vec,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNTWIDTH-1:0] out_count,
  output logic                busy
);

  localparam int IDXW = idx_width(NCHUNK);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [CNTWIDTH-1:0] acc_q, acc_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [CNTWIDTH-1:0] out_count_q, out_count_d;

  logic [CCW-1:0]      chunk_count;
  logic [CNTWIDTH-1:0] sum;
  logic                last_chunk;

  count_ones #(
    .WIDTH (CHUNK)
  ) u_count_ones (
    .vec_i   (shreg_q[CHUNK-1:0]),
    .count_o (chunk_count)
  );

  assign sum        = acc_q + CNTWIDTH'(chunk_count);
  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_count_q <= out_count_d;
    end
  end

  // Abort outranks the output handshake and never touches the held result.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_count_d = out_count_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_vec;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          shreg_d = shreg_q >> CHUNK;
          acc_d   = sum;
          idx_d   = idx_q + IDXW'(1);
          if (last_chunk) begin
            out_count_d = sum;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_count = out_count_q;

endmodule

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq: directed corner cases followed by a
// random stream scored against a queue of reference popcounts.
`timescale 1ns/1ps
module tb_popcount_seq;

  localparam int WIDTH  = 128;
  localparam int CHUNK  = 32;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = $clog2(WIDTH + 1);
  localparam int NSTREAM = 1000;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [CNTW-1:0]  out_count;
  logic             busy;

  int vectorsApplied = 0;
  int miscompares    = 0;

  popcount_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int got, input int expd);
    vectorsApplied++;
    if (got !== expd) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expd);
    end
  endtask

  function automatic int refCount(input logic [WIDTH-1:0] v);
    return $countones(v);
  endfunction

  function automatic logic [WIDTH-1:0] randVec();
    logic [WIDTH-1:0] a, b;
    for (int w = 0; w < WIDTH / 32; w++) begin
      a[w*32 +: 32] = $urandom;
      b[w*32 +: 32] = $urandom;
    end
    case ($urandom_range(0, 4))
      0:       return a & b;
      1:       return '1;
      2:       return WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      default: return a;
    endcase
  endfunction

  // Offers vec at the current falling edge (block idle) and waits for the result.
  task automatic applyStimulus(input logic [WIDTH-1:0] vec, input int expCount, input string tag);
    int lat = 0;
    in_valid = 1'b1;
    in_vec   = vec;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      in_vec   = '0;
      lat++;
    end while (!out_valid && lat < 20);
    checkOutput({tag, " latency"}, lat, NCHUNK + 1);
    checkOutput({tag, " count"}, int'(out_count), expCount);
  endtask

  task automatic completeHandshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " in_ready after handshake"}, int'(in_ready), 1);
    checkOutput({tag, " out_valid after handshake"}, int'(out_valid), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] pattern01;
    int heldCount;
    int pulses;
    int lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < WIDTH / 2; i++) pattern01[2*i +: 2] = 2'b01;

    #1;
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_count", int'(out_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus('1, 128, "all ones");
    completeHandshake("all ones");
    applyStimulus('0, 0, "zero");
    completeHandshake("zero");
    applyStimulus(pattern01, 64, "pattern01");
    completeHandshake("pattern01");
    v = '0;
    v[WIDTH-1] = 1'b1;
    applyStimulus(v, 1, "msb only");
    completeHandshake("msb only");

    // Result is held under back-pressure while a new request waits.
    v = randVec();
    heldCount = refCount(v);
    applyStimulus(v, heldCount, "hold");
    in_valid = 1'b1;
    in_vec   = '1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("hold out_valid", int'(out_valid), 1);
      checkOutput("hold out_count", int'(out_count), heldCount);
      checkOutput("hold in_ready", int'(in_ready), 0);
    end
    completeHandshake("hold");
    applyStimulus('1, 128, "after hold");
    completeHandshake("after hold");

    // Asynchronous reset while the third chunk is being counted.
    in_valid = 1'b1;
    in_vec   = randVec();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun reset out_valid", int'(out_valid), 0);
    checkOutput("midrun reset out_count", int'(out_count), 0);
    checkOutput("midrun reset busy", int'(busy), 0);
    checkOutput("midrun reset in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(WIDTH'(4'hF), 4, "after reset");
    completeHandshake("after reset");

    // Abort during RUN at the second chunk.
    in_valid = 1'b1;
    in_vec   = '1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort run busy", int'(busy), 0);
    checkOutput("abort run out_count", int'(out_count), 4);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checkOutput("abort run out_valid pulses", pulses, 0);

    // Abort in IDLE must not block the accept.
    v = randVec();
    heldCount = refCount(v);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_vec   = v;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    checkOutput("idle abort accepted", int'(busy), 1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("idle abort latency", lat, NCHUNK + 1);
    checkOutput("idle abort count", int'(out_count), heldCount);

    // Abort together with out_ready in DONE drops the result, keeps the count.
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    checkOutput("done abort in_ready", int'(in_ready), 1);
    checkOutput("done abort out_valid", int'(out_valid), 0);
    checkOutput("done abort out_count", int'(out_count), heldCount);

    // Random stream with random valid/ready, scored in order.
    begin
      int expQ[$];
      int sent = 0;
      int cycles = 0;
      while ((sent < NSTREAM || expQ.size() > 0) && cycles < 40000) begin
        @(negedge clk);
        cycles++;
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) checkOutput("stream unexpected result", 1, 0);
          else checkOutput("stream count", int'(out_count), expQ.pop_front());
        end
        in_valid = (sent < NSTREAM) && ($urandom_range(0, 2) != 0);
        in_vec   = randVec();
        if (in_valid && in_ready) begin
          expQ.push_back(refCount(in_vec));
          sent++;
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("stream drained", (NSTREAM - sent) + expQ.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
